// File: rtl/fifo_pkg.sv
// Shared sizing constants and helpers for the threshold FIFO and its storage array.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 12;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int CNT_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;

  function automatic int depth_of(input int addr_width);
    return 2 ** addr_width;
  endfunction

  // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable.
  function automatic int cnt_width_of(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/memoria_dual.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one synchronous registered read port.
// Array is not reset; only the read-data register is cleared by reset.
module memoria_dual
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Reads the pre-edge contents, so a same-slot write while full never bypasses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_umbral.sv
// Parametrised synchronous FIFO with runtime almost-empty/almost-full thresholds,
// occupancy count, registered read-valid strobe and sticky overflow/underflow flags.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  data_valid,
  output logic                  FIFO_empty,
  output logic                  FIFO_full,
  output logic                  FIFO_almost_empty,
  output logic                  FIFO_almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error_overflow,
  output logic                  error_underflow
);

  localparam int              CW        = cnt_width_of(ADDR_WIDTH);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(depth_of(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_set;
  logic                  unf_set;

  assign count             = count_q;
  assign FIFO_empty        = (count_q == '0);
  assign FIFO_full         = (count_q == DEPTH_CNT);
  assign FIFO_almost_empty = (count_q <= umbral_bajo);
  assign FIFO_almost_full  = (count_q >= umbral_alto);

  // A read on a full FIFO frees the slot the write needs in the same edge.
  assign rd_acc  = Enable && read_enable && !FIFO_empty;
  assign wr_acc  = Enable && write_enable && (!FIFO_full || rd_acc);

  // Read+write while empty is a normal request, so it is not an underflow.
  assign ovf_set = write_enable && FIFO_full && !rd_acc;
  assign unf_set = read_enable && FIFO_empty && !write_enable;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) data_valid <= 1'b0;
    else        data_valid <= rd_acc;
  end

  // Set has priority over clear; nothing changes while Enable is low.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      error_overflow  <= 1'b0;
      error_underflow <= 1'b0;
    end else if (Enable) begin
      if (ovf_set)        error_overflow  <= 1'b1;
      else if (clear_err) error_overflow  <= 1'b0;
      if (unf_set)        error_underflow <= 1'b1;
      else if (clear_err) error_underflow <= 1'b0;
    end
  end

  memoria_dual #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (Reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (FIFO_data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (FIFO_data_out)
  );

endmodule

// File: tb/tb_fifo_umbral.sv
// Bench for fifo_umbral: directed scenarios plus randomized traffic against a queue model.
module tb_fifo_umbral;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic        write_enable;
  logic        read_enable;
  logic [11:0] FIFO_data_in;
  logic [3:0]  umbral_bajo;
  logic [3:0]  umbral_alto;
  logic        clear_err;
  logic [11:0] FIFO_data_out;
  logic        data_valid;
  logic        FIFO_empty;
  logic        FIFO_full;
  logic        FIFO_almost_empty;
  logic        FIFO_almost_full;
  logic [3:0]  count;
  logic        error_overflow;
  logic        error_underflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a plain queue with at most 8 entries.
  logic [11:0] mq[$];
  logic [11:0] m_dout;
  bit          m_dv, m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_umbral #(.DATA_WIDTH(12), .ADDR_WIDTH(3)) dut (
    .clk               (clk),
    .Reset             (Reset),
    .Enable            (Enable),
    .write_enable      (write_enable),
    .read_enable       (read_enable),
    .FIFO_data_in      (FIFO_data_in),
    .umbral_bajo       (umbral_bajo),
    .umbral_alto       (umbral_alto),
    .clear_err         (clear_err),
    .FIFO_data_out     (FIFO_data_out),
    .data_valid        (data_valid),
    .FIFO_empty        (FIFO_empty),
    .FIFO_full         (FIFO_full),
    .FIFO_almost_empty (FIFO_almost_empty),
    .FIFO_almost_full  (FIFO_almost_full),
    .count             (count),
    .error_overflow    (error_overflow),
    .error_underflow   (error_underflow)
  );

  task automatic model_step();
    int  n;
    bit  rd, wr;
    n = mq.size();
    m_dv = 1'b0;
    if (!Enable) return;
    rd = read_enable && (n > 0);
    wr = write_enable && ((n < 8) || rd);
    if (write_enable && n == 8 && !rd) m_ovf = 1'b1;
    else if (clear_err)                m_ovf = 1'b0;
    if (read_enable && n == 0 && !write_enable) m_unf = 1'b1;
    else if (clear_err)                         m_unf = 1'b0;
    if (rd) begin
      m_dout = mq.pop_front();
      m_dv   = 1'b1;
    end
    if (wr) mq.push_back(FIFO_data_in);
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, settle 1 unit.
  task automatic cyc(input logic en, input logic we, input logic re, input logic clr,
                     input logic [11:0] d);
    @(negedge clk);
    Enable = en; write_enable = we; read_enable = re; clear_err = clr; FIFO_data_in = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Enable = 1'b1; write_enable = 1'b0; read_enable = 1'b0; clear_err = 1'b0;
    Reset = 1'b0;
    model_reset();
    #2 Reset = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (FIFO_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", FIFO_empty); end
    n_cmp++; if (FIFO_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", FIFO_full); end
    n_cmp++; if (FIFO_almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae: got %b want 1", FIFO_almost_empty); end
    n_cmp++; if (FIFO_almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af: got %b want 0", FIFO_almost_full); end
    n_cmp++; if (FIFO_data_out !== 12'h000) begin n_err++; $display("FAIL reset_dout: got %h want 000", FIFO_data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b want 0", data_valid); end
    n_cmp++; if ({error_overflow, error_underflow} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b%b want 00", error_overflow, error_underflow); end
    umbral_alto = 4'd0;
    #1;
    n_cmp++; if (FIFO_almost_full !== 1'b1) begin n_err++; $display("FAIL reset_af_zero_thr: got %b want 1", FIFO_almost_full); end
    umbral_alto = 4'd6;
    do_reset();
  endtask

  task automatic test_basic();
    logic [11:0] vals [5];
    vals = '{12'hFFF, 12'hACF, 12'h1B7, 12'hB08, 12'h611};
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, vals[i]);
    n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL basic_count: got %0d want 5", count); end
    n_cmp++; if (FIFO_almost_empty !== 1'b0) begin n_err++; $display("FAIL basic_ae: got %b want 0", FIFO_almost_empty); end
    n_cmp++; if (FIFO_almost_full !== 1'b0) begin n_err++; $display("FAIL basic_af: got %b want 0", FIFO_almost_full); end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 0, 12'h000);
      n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL basic_dv[%0d]: got %b want 1", i, data_valid); end
      n_cmp++; if (FIFO_data_out !== vals[i]) begin n_err++; $display("FAIL basic_dout[%0d]: got %h want %h", i, FIFO_data_out, vals[i]); end
    end
    cyc(1, 0, 0, 0, 12'h000);
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL basic_dv_idle: got %b want 0", data_valid); end
    n_cmp++; if (FIFO_empty !== 1'b1) begin n_err++; $display("FAIL basic_empty: got %b want 1", FIFO_empty); end
    n_cmp++; if (FIFO_data_out !== 12'h611) begin n_err++; $display("FAIL basic_dout_hold: got %h want 611", FIFO_data_out); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 0, 0, 12'($urandom));
      n_cmp++; if (FIFO_almost_full !== (i >= 6)) begin n_err++; $display("FAIL fill_af[%0d]: got %b want %b", i, FIFO_almost_full, i >= 6); end
      n_cmp++; if (FIFO_full !== (i == 8)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, FIFO_full, i == 8); end
    end
    cyc(1, 1, 0, 0, 12'h5A5);
    n_cmp++; if (error_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", error_overflow); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", count); end
    cyc(1, 0, 0, 1, 12'h000);
    n_cmp++; if (error_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", error_overflow); end
    cyc(1, 1, 0, 1, 12'h5A5);
    n_cmp++; if (error_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", error_overflow); end
    cyc(1, 0, 0, 1, 12'h000);
  endtask

  // Continues from the full FIFO left by test_fill_overflow.
  task automatic test_full_rw();
    logic [11:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = mq[0];
      cyc(1, 1, 1, 0, 12'($urandom));
      n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fullrw_count[%0d]: got %0d want 8", i, count); end
      n_cmp++; if (FIFO_data_out !== exp || data_valid !== 1'b1) begin n_err++; $display("FAIL fullrw_dout[%0d]: got %h/%b want %h/1", i, FIFO_data_out, data_valid, exp); end
      n_cmp++; if (error_overflow !== 1'b0) begin n_err++; $display("FAIL fullrw_ovf[%0d]: got %b want 0", i, error_overflow); end
    end
    for (int i = 0; i < 8; i++) begin
      exp = mq[0];
      cyc(1, 0, 1, 0, 12'h000);
      n_cmp++; if (FIFO_data_out !== exp) begin n_err++; $display("FAIL wrap_dout[%0d]: got %h want %h", i, FIFO_data_out, exp); end
    end
    n_cmp++; if (FIFO_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", FIFO_empty); end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(1, 0, 1, 0, 12'h000);
    n_cmp++; if (error_underflow !== 1'b1) begin n_err++; $display("FAIL unf_set: got %b want 1", error_underflow); end
    n_cmp++; if (data_valid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL unf_state: got dv=%b cnt=%0d want dv=0 cnt=0", data_valid, count); end
    cyc(1, 0, 0, 1, 12'h000);
    cyc(1, 1, 1, 0, 12'h3C3);
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL empty_rw_count: got %0d want 1", count); end
    n_cmp++; if (error_underflow !== 1'b0 || data_valid !== 1'b0) begin n_err++; $display("FAIL empty_rw_flags: got unf=%b dv=%b want 0/0", error_underflow, data_valid); end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 12'(16'h0100 + i));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 12'hEEE);
      n_cmp++; if (count !== 4'd4 || data_valid !== 1'b0) begin n_err++; $display("FAIL freeze[%0d]: got cnt=%0d dv=%b want 4/0", i, count, data_valid); end
    end
    n_cmp++; if (FIFO_almost_empty !== 1'b0) begin n_err++; $display("FAIL freeze_ae_thr2: got %b want 0", FIFO_almost_empty); end
    umbral_bajo = 4'd4;
    #1;
    n_cmp++; if (FIFO_almost_empty !== 1'b1) begin n_err++; $display("FAIL freeze_ae_thr4: got %b want 1", FIFO_almost_empty); end
    umbral_bajo = 4'd2;
    cyc(1, 0, 1, 0, 12'h000);
    n_cmp++; if (FIFO_data_out !== 12'h100) begin n_err++; $display("FAIL freeze_first: got %h want 100", FIFO_data_out); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 0, 1, 0, 12'h000);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 12'(16'h0A00 + i));
    cyc(1, 0, 1, 0, 12'h000);
    #2 Reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (count !== 4'd0 || FIFO_empty !== 1'b1) begin n_err++; $display("FAIL areset_count: got cnt=%0d empty=%b want 0/1", count, FIFO_empty); end
    n_cmp++; if ({error_overflow, error_underflow} !== 2'b00) begin n_err++; $display("FAIL areset_errs: got %b%b want 00", error_overflow, error_underflow); end
    n_cmp++; if (data_valid !== 1'b0 || FIFO_data_out !== 12'h000) begin n_err++; $display("FAIL areset_out: got dv=%b dout=%h want 0/000", data_valid, FIFO_data_out); end
    @(negedge clk);
    Reset = 1'b1;
    cyc(1, 1, 1, 0, 12'h777);
    n_cmp++; if (count !== 4'd1 || data_valid !== 1'b0) begin n_err++; $display("FAIL areset_after: got cnt=%0d dv=%b want 1/0", count, data_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        umbral_bajo = 4'($urandom_range(0, 10));
        umbral_alto = 4'($urandom_range(0, 10));
      end
      cyc(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), 12'($urandom));
      n_cmp++; if (count !== 4'(mq.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, mq.size()); end
      n_cmp++; if (data_valid !== m_dv) begin n_err++; $display("FAIL rnd_dv[%0d]: got %b want %b", i, data_valid, m_dv); end
      n_cmp++; if (FIFO_data_out !== m_dout) begin n_err++; $display("FAIL rnd_dout[%0d]: got %h want %h", i, FIFO_data_out, m_dout); end
      n_cmp++; if ({error_overflow, error_underflow} !== {m_ovf, m_unf}) begin n_err++; $display("FAIL rnd_errs[%0d]: got %b%b want %b%b", i, error_overflow, error_underflow, m_ovf, m_unf); end
      n_cmp++; if ({FIFO_empty, FIFO_full} !== {mq.size() == 0, mq.size() == 8}) begin n_err++; $display("FAIL rnd_ef[%0d]: got %b%b want %b%b", i, FIFO_empty, FIFO_full, mq.size() == 0, mq.size() == 8); end
      n_cmp++; if ({FIFO_almost_empty, FIFO_almost_full} !== {mq.size() <= int'(umbral_bajo), mq.size() >= int'(umbral_alto)}) begin n_err++; $display("FAIL rnd_thr[%0d]: got %b%b cnt=%0d lo=%0d hi=%0d", i, FIFO_almost_empty, FIFO_almost_full, mq.size(), umbral_bajo, umbral_alto); end
    end
    umbral_bajo = 4'd2;
    umbral_alto = 4'd6;
  endtask

  initial begin
    Reset = 1'b0; Enable = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
    clear_err = 1'b0; FIFO_data_in = '0; umbral_bajo = 4'd2; umbral_alto = 4'd6;
    model_reset();
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_rw();
    test_underflow();
    test_enable_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Parametrised synchronous FIFO, the successor to the fixed 12-bit / 3-bit-threshold memory FIFO.
- Depth, data width and threshold width are generic.
- Adds:
  - runtime almost-empty and almost-full thresholds, sized to the depth;
  - an occupancy count output;
  - a registered read-data valid strobe;
  - sticky overflow and underflow error flags.
- Sits between producer and consumer blocks of the memory subsystem, one clock domain.

Parameters:
- DATA_WIDTH, 12, width of FIFO_data_in and FIFO_data_out.
- ADDR_WIDTH, 3, pointer width. DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Enable  input  1  global enable. Low freezes all state and suppresses error capture.
- write_enable  input  1  write request.
- read_enable  input  1  read request.
- FIFO_data_in  input  DATA_WIDTH  write data.
- umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold.
- umbral_alto  input  ADDR_WIDTH+1  almost-full threshold.
- clear_err  input  1  synchronous clear of the sticky error flags.
- FIFO_data_out  output  DATA_WIDTH  registered read data.
- data_valid  output  1  one-cycle strobe; FIFO_data_out was updated this cycle.
- FIFO_empty  output  1  count == 0.
- FIFO_full  output  1  count == DEPTH.
- FIFO_almost_empty  output  1  count <= umbral_bajo.
- FIFO_almost_full  output  1  count >= umbral_alto.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- error_overflow  output  1  sticky; a write was refused while full.
- error_underflow  output  1  sticky; a read was refused while empty.

Behaviour:
- Reset low, asynchronous, takes effect immediately:
  - wr_ptr, rd_ptr, count = 0;
  - FIFO_data_out = 0; data_valid = 0;
  - error_overflow = 0; error_underflow = 0.
  - Memory contents are not cleared.
- Flags are combinational decodes of the count register, so they reflect the state after the last edge with zero extra latency.
  - After reset: FIFO_empty = 1, FIFO_full = 0, FIFO_almost_empty = 1.
  - After reset, FIFO_almost_full = (umbral_alto == 0).
- Accept rules, evaluated each rising edge with Enable = 1:
  - rd_acc = read_enable && !FIFO_empty.
  - wr_acc = write_enable && (!FIFO_full || rd_acc).
- Accepted write: mem[wr_ptr] <= FIFO_data_in; wr_ptr <= wr_ptr + 1, modulo DEPTH, natural wrap.
- Accepted read: FIFO_data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr + 1, modulo DEPTH; data_valid <= 1.
  - Read latency is one edge: data appears after the accepting edge and holds until the next accepted read.
  - data_valid is 0 on every edge without rd_acc.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither are accepted.
- Simultaneous read and write:
  - When empty: the read is refused and the write is accepted. No fall-through; underflow is not flagged, since this is a normal request while empty.
  - When full: both are accepted, count stays DEPTH, and the freed slot is rewritten.
- Errors:
  - error_overflow sets on write_enable && FIFO_full && !rd_acc.
  - error_underflow sets on read_enable && FIFO_empty && !write_enable.
  - Both hold until reset, or until clear_err = 1 at an edge.
  - If set and clear coincide, set wins.
- Enable = 0: no pointer, count, data or error change. data_valid goes to 0. Outputs hold.
- Thresholds are sampled combinationally and take effect immediately.
  - umbral_alto > DEPTH means almost_full never asserts.
  - umbral_bajo >= DEPTH means almost_empty is always asserted.
- Reset asserted mid-transfer aborts any in-flight access; the first edge after release behaves as from empty.

Decomposition:
- Package fifo_pkg holds:
  - function clog2-free DEPTH calculation (2**ADDR_WIDTH);
  - default DATA_WIDTH / ADDR_WIDTH constants;
  - the count width ADDR_WIDTH+1 as a constant.
- One sub-module, memoria_dual: DEPTH x DATA_WIDTH array with one synchronous write port and one synchronous read port. No reset on the array. Read data is registered inside it.
- Pointers, count, flags and errors live in fifo_umbral.

Test Plan:
All scenarios use DATA_WIDTH = 12, ADDR_WIDTH = 3 (DEPTH = 8), umbral_bajo = 2, umbral_alto = 6.
- Reset then write 12'hFFF, 12'hACF, 12'h1B7, 12'hB08, 12'h611:
  - count = 5, almost_empty = 0, almost_full = 0.
  - Then 5 reads return the values in the same order, each with data_valid = 1 one edge after acceptance; finally empty = 1.
- Write 8 words:
  - almost_full asserts when count = 6; full asserts at 8.
  - A 9th write sets error_overflow; count stays 8.
  - clear_err clears the flag.
- Full FIFO with write_enable and read_enable held for 4 edges:
  - count stays 8, the oldest 4 words emerge in order, no error.
  - Pointers wrap past 7 correctly.
- Empty FIFO:
  - read_enable alone: error_underflow = 1, data_valid = 0, count = 0.
  - Read and write together: count = 1, no new error.
- 4 words stored, Enable = 0 for 3 edges with requests active:
  - count stays 4, data_valid = 0.
  - Changing umbral_bajo to 4 asserts almost_empty immediately.
- 3 words stored, Reset pulled low between edges:
  - outputs clear at once, without waiting for an edge;
  - count = 0, empty = 1, errors = 0.
